ucie_multi_protocol_adapter: RTL and testbench
==============================================

Name: ucie_multi_protocol_adapter

Overview:
- Parametrised next-generation protocol adapter between the link-side flit stream and NUM_PROTOCOLS protocol-layer stacks.
- Downstream (link to protocol): demuxes flits by protocol ID into per-protocol FWFT FIFOs. Disabled or unknown IDs are dropped and counted.
- Upstream (protocol to link): arbitrates between protocols with packet locking. The mode is selectable: round-robin or strict priority.

Parameters:
NUM_PROTOCOLS, 4, number of protocol stacks (2..16)
FLIT_W, 256, flit data width
VC_W, 8, virtual-channel tag width
PID_W, 4, protocol-ID width; must satisfy 2**PID_W >= NUM_PROTOCOLS
FIFO_DEPTH, 4, entries per downstream FIFO; power of two, >= 2
CNT_W, 16, width of the saturating drop counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
protocol_enable  in  NUM_PROTOCOLS  per-protocol enable
arb_mode  in  1  0 = round-robin; 1 = strict priority (index 0 highest)
lnk_rx_valid  in  1  downstream flit valid
lnk_rx_ready  out  1  downstream accept
lnk_rx_data  in  FLIT_W  downstream flit
lnk_rx_pid  in  PID_W  destination protocol ID
lnk_rx_vc  in  VC_W  VC tag
proto_tx_valid  out  NUM_PROTOCOLS  per-protocol FIFO head valid
proto_tx_ready  in  NUM_PROTOCOLS  per-protocol pop
proto_tx_data  out  NUM_PROTOCOLS*FLIT_W  FIFO head flits, packed, index 0 in LSBs
proto_tx_vc  out  NUM_PROTOCOLS*VC_W  FIFO head VC tags
proto_rx_valid  in  NUM_PROTOCOLS  upstream request
proto_rx_ready  out  NUM_PROTOCOLS  upstream accept
proto_rx_data  in  NUM_PROTOCOLS*FLIT_W  upstream flits
proto_rx_vc  in  NUM_PROTOCOLS*VC_W  upstream VC tags
proto_rx_sop  in  NUM_PROTOCOLS  start of packet
proto_rx_eop  in  NUM_PROTOCOLS  end of packet
lnk_tx_valid  out  1  upstream flit valid
lnk_tx_ready  in  1  link accept
lnk_tx_data  out  FLIT_W  granted flit
lnk_tx_vc  out  VC_W  granted VC tag
lnk_tx_pid  out  PID_W  granted protocol index
lnk_tx_sop  out  1  pass-through SOP
lnk_tx_eop  out  1  pass-through EOP
drop_count  out  NUM_PROTOCOLS*CNT_W  flits dropped because the target protocol was disabled
unknown_pid_count  out  CNT_W  flits dropped because pid >= NUM_PROTOCOLS

Behaviour:
Reset:
- All FIFOs are empty and all counters are 0.
- The arbiter is in IDLE, with RR pointer = 0 and grant = 0.
- Resulting outputs: proto_tx_valid = 0, lnk_tx_valid = 0, lnk_tx_* data/vc/pid/sop/eop = 0.
- Reset asserted mid-packet discards FIFO contents and any lock immediately.

Downstream path:
- A handshake is lnk_rx_valid && lnk_rx_ready.
- If pid < NUM_PROTOCOLS and the target is enabled: lnk_rx_ready = !full[pid], and the flit plus VC tag are pushed.
- If the target is disabled, or pid is out of range: lnk_rx_ready = 1, the flit is discarded, and the matching counter increments by 1, saturating at all-ones.
- Latency: a push in cycle N gives proto_tx_valid = 1 in cycle N+1 (registered storage, FWFT head).
- A FIFO pops on proto_tx_valid && proto_tx_ready.
- Push and pop in the same cycle on a non-empty FIFO keep the occupancy unchanged.
- Full is computed from the registered occupancy, so there is no push bypass when full, even with a simultaneous pop.
- Pointers wrap modulo FIFO_DEPTH. Occupancy is counted in log2(FIFO_DEPTH)+1 bits.
- Disabling a protocol does not flush its FIFO. Entries already queued still drain.

Upstream arbiter, state IDLE:
- Candidates are i with proto_rx_valid[i] && protocol_enable[i].
- arb_mode = 1: the lowest candidate index wins.
- arb_mode = 0: the first candidate at or after the RR pointer wins, searching circularly.
- The winner is combinationally driven onto lnk_tx_*, with lnk_tx_pid = winner index. lnk_tx_valid = 1 if any candidate exists.
- proto_rx_ready[winner] = lnk_tx_ready. All other proto_rx_ready are 0.
- On a handshake with eop = 0: go to LOCKED and register grant = winner.
- On a handshake with eop = 1: stay in IDLE (single-beat packet).
- The RR pointer updates only on an eop handshake. It becomes (winner+1) mod NUM_PROTOCOLS.

Upstream arbiter, state LOCKED:
- Only proto_rx_*[grant] is muxed to lnk_tx_*. lnk_tx_valid = proto_rx_valid[grant].
- proto_rx_ready[grant] = lnk_tx_ready. All others are 0.
- protocol_enable[grant] dropping during LOCKED is ignored until EOP, so the packet always completes.
- A change of arb_mode takes effect only in IDLE.
- On an eop handshake: return to IDLE and update the RR pointer.

Upstream general rules:
- SOP is pass-through only. A non-SOP beat seen in IDLE is arbitrated like any other beat.
- Upstream valid/data may be held or change freely while ready = 0. The adapter adds no buffering and no upstream latency.

Test Plan:
- Reset release, then pid = 2 flit D0 accepted at cycle 5 -> proto_tx_valid[2] = 1 with data D0 at cycle 6; all other valids stay 0.
- Fill protocol 1 with 4 flits while proto_tx_ready[1] = 0 -> lnk_rx_ready = 0 on the 5th; assert ready -> the 4 flits emerge in order, and the 5th is accepted one cycle after the first pop.
- protocol_enable = 4'b1011, send 3 flits with pid = 2 and 2 with pid = 7 (PID_W = 4) -> lnk_rx_ready = 1 throughout, drop_count[2] = 3, unknown_pid_count = 2.
- arb_mode = 0, all 4 protocols continuously sending single-beat packets -> grant order 0,1,2,3,0. arb_mode = 1 -> index 0 always granted.
- Protocol 3 sends a 3-beat packet (sop, -, eop) while protocol 0 requests; lnk_tx_ready toggles 1/0 -> all 3 beats from pid 3 are contiguous, then protocol 0 is granted.
- Assert rst_n = 0 in the middle of a LOCKED packet with FIFOs partially full -> next cycle all valids are 0 and counters are 0; after release the arbiter is IDLE with RR pointer = 0.

Source files
------------

// File: rtl/ucie_multi_protocol_adapter.sv
// Multi-protocol adapter: demuxes link flits into per-protocol FWFT FIFOs and
// arbitrates protocol stacks onto the link with packet locking (RR or strict).
module ucie_multi_protocol_adapter #(
  parameter int NUM_PROTOCOLS = 4,
  parameter int FLIT_W        = 256,
  parameter int VC_W          = 8,
  parameter int PID_W         = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_W         = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PROTOCOLS-1:0]        protocol_enable,
  input  logic                            arb_mode,
  input  logic                            lnk_rx_valid,
  output logic                            lnk_rx_ready,
  input  logic [FLIT_W-1:0]               lnk_rx_data,
  input  logic [PID_W-1:0]                lnk_rx_pid,
  input  logic [VC_W-1:0]                 lnk_rx_vc,
  output logic [NUM_PROTOCOLS-1:0]        proto_tx_valid,
  input  logic [NUM_PROTOCOLS-1:0]        proto_tx_ready,
  output logic [NUM_PROTOCOLS*FLIT_W-1:0] proto_tx_data,
  output logic [NUM_PROTOCOLS*VC_W-1:0]   proto_tx_vc,
  input  logic [NUM_PROTOCOLS-1:0]        proto_rx_valid,
  output logic [NUM_PROTOCOLS-1:0]        proto_rx_ready,
  input  logic [NUM_PROTOCOLS*FLIT_W-1:0] proto_rx_data,
  input  logic [NUM_PROTOCOLS*VC_W-1:0]   proto_rx_vc,
  input  logic [NUM_PROTOCOLS-1:0]        proto_rx_sop,
  input  logic [NUM_PROTOCOLS-1:0]        proto_rx_eop,
  output logic                            lnk_tx_valid,
  input  logic                            lnk_tx_ready,
  output logic [FLIT_W-1:0]               lnk_tx_data,
  output logic [VC_W-1:0]                 lnk_tx_vc,
  output logic [PID_W-1:0]                lnk_tx_pid,
  output logic                            lnk_tx_sop,
  output logic                            lnk_tx_eop,
  output logic [NUM_PROTOCOLS*CNT_W-1:0]  drop_count,
  output logic [CNT_W-1:0]                unknown_pid_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam int PW = $clog2(NUM_PROTOCOLS);
  localparam logic [PID_W:0] NUM_PID   = (PID_W+1)'(NUM_PROTOCOLS);
  localparam logic [OW-1:0]  DEPTH_OCC = OW'(FIFO_DEPTH);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} arb_state_t;

  logic [FLIT_W-1:0] mem_data_r [NUM_PROTOCOLS][FIFO_DEPTH];
  logic [VC_W-1:0]   mem_vc_r   [NUM_PROTOCOLS][FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r   [NUM_PROTOCOLS];
  logic [AW-1:0]     rd_ptr_r   [NUM_PROTOCOLS];
  logic [OW-1:0]     occ_r      [NUM_PROTOCOLS];
  logic [CNT_W-1:0]  drop_cnt_r [NUM_PROTOCOLS];
  logic [CNT_W-1:0]  unk_cnt_r;

  logic                     pid_in_range_s;
  logic [NUM_PROTOCOLS-1:0] sel_s, full_s, head_valid_s;
  logic [NUM_PROTOCOLS-1:0] push_s, pop_s, drop_dis_s;
  logic                     drop_unk_s;

  arb_state_t               state_r;
  logic [PW-1:0]            grant_r, rr_ptr_r;
  logic [NUM_PROTOCOLS-1:0] cand_s, pick_s;
  logic [PW-1:0]            win_s, sel_idx_s, next_rr_s;
  logic                     found_s, locked_s, tx_valid_s, hs_s, eop_hs_s;
  int                       idx_s;

  // Downstream decode: route by pid, drop to a counter when disabled or out of range
  always_comb begin
    sel_s          = {NUM_PROTOCOLS{1'b0}};
    full_s         = {NUM_PROTOCOLS{1'b0}};
    head_valid_s   = {NUM_PROTOCOLS{1'b0}};
    pid_in_range_s = ({1'b0, lnk_rx_pid} < NUM_PID);
    for (int i = 0; i < NUM_PROTOCOLS; i++) begin
      sel_s[i]        = pid_in_range_s && (lnk_rx_pid == PID_W'(i));
      full_s[i]       = (occ_r[i] == DEPTH_OCC);
      head_valid_s[i] = (occ_r[i] != {OW{1'b0}});
    end
    // Backpressure only when the addressed, enabled FIFO is full
    lnk_rx_ready = !pid_in_range_s || (|(sel_s & ~(protocol_enable & full_s)));
    push_s       = sel_s & protocol_enable & ~full_s & {NUM_PROTOCOLS{lnk_rx_valid}};
    drop_dis_s   = sel_s & ~protocol_enable & {NUM_PROTOCOLS{lnk_rx_valid}};
    drop_unk_s   = lnk_rx_valid && !pid_in_range_s;
    pop_s        = head_valid_s & proto_tx_ready;
  end

  // FIFO pointers and occupancy; full uses registered occupancy, so no bypass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PROTOCOLS; i++) begin
        wr_ptr_r[i] <= {AW{1'b0}};
        rd_ptr_r[i] <= {AW{1'b0}};
        occ_r[i]    <= {OW{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_PROTOCOLS; i++) begin
        if (push_s[i]) wr_ptr_r[i] <= wr_ptr_r[i] + AW'(1);
        if (pop_s[i])  rd_ptr_r[i] <= rd_ptr_r[i] + AW'(1);
        case ({push_s[i], pop_s[i]})
          2'b10:   occ_r[i] <= occ_r[i] + OW'(1);
          2'b01:   occ_r[i] <= occ_r[i] - OW'(1);
          default: occ_r[i] <= occ_r[i];
        endcase
      end
    end
  end

  // FIFO storage; contents are qualified by occupancy and need no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PROTOCOLS; i++) begin
      if (push_s[i]) begin
        mem_data_r[i][wr_ptr_r[i]] <= lnk_rx_data;
        mem_vc_r[i][wr_ptr_r[i]]   <= lnk_rx_vc;
      end
    end
  end

  // Saturating drop counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PROTOCOLS; i++) drop_cnt_r[i] <= {CNT_W{1'b0}};
      unk_cnt_r <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_PROTOCOLS; i++) begin
        if (drop_dis_s[i] && (drop_cnt_r[i] != {CNT_W{1'b1}}))
          drop_cnt_r[i] <= drop_cnt_r[i] + CNT_W'(1);
      end
      if (drop_unk_s && (unk_cnt_r != {CNT_W{1'b1}}))
        unk_cnt_r <= unk_cnt_r + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_PROTOCOLS; g++) begin : g_out
    assign proto_tx_data[g*FLIT_W +: FLIT_W] = mem_data_r[g][rd_ptr_r[g]];
    assign proto_tx_vc[g*VC_W +: VC_W]       = mem_vc_r[g][rd_ptr_r[g]];
    assign drop_count[g*CNT_W +: CNT_W]      = drop_cnt_r[g];
  end
  assign proto_tx_valid    = head_valid_s;
  assign unknown_pid_count = unk_cnt_r;

  // Upstream arbitration and flit mux; LOCKED ignores enable and arb_mode
  always_comb begin
    cand_s  = proto_rx_valid & protocol_enable;
    win_s   = {PW{1'b0}};
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 0; k < NUM_PROTOCOLS; k++) begin
      idx_s = arb_mode ? k : ((int'(rr_ptr_r) + k) % NUM_PROTOCOLS);
      if (cand_s[idx_s] && !found_s) begin
        win_s   = PW'(idx_s);
        found_s = 1'b1;
      end else begin
        win_s   = win_s;
        found_s = found_s;
      end
    end
    locked_s   = (state_r == ST_LOCKED);
    sel_idx_s  = locked_s ? grant_r : win_s;
    tx_valid_s = locked_s ? proto_rx_valid[grant_r] : found_s;
    pick_s         = {NUM_PROTOCOLS{1'b0}};
    proto_rx_ready = {NUM_PROTOCOLS{1'b0}};
    lnk_tx_data    = {FLIT_W{1'b0}};
    lnk_tx_vc      = {VC_W{1'b0}};
    for (int i = 0; i < NUM_PROTOCOLS; i++) begin
      pick_s[i]         = tx_valid_s && (sel_idx_s == PW'(i));
      proto_rx_ready[i] = lnk_tx_ready && (locked_s || found_s) && (sel_idx_s == PW'(i));
      lnk_tx_data       = lnk_tx_data | ({FLIT_W{pick_s[i]}} & proto_rx_data[i*FLIT_W +: FLIT_W]);
      lnk_tx_vc         = lnk_tx_vc | ({VC_W{pick_s[i]}} & proto_rx_vc[i*VC_W +: VC_W]);
    end
    lnk_tx_valid = tx_valid_s;
    lnk_tx_sop   = |(pick_s & proto_rx_sop);
    lnk_tx_eop   = |(pick_s & proto_rx_eop);
    lnk_tx_pid   = tx_valid_s ? PID_W'(sel_idx_s) : {PID_W{1'b0}};
    hs_s         = tx_valid_s && lnk_tx_ready;
    eop_hs_s     = hs_s && lnk_tx_eop;
    next_rr_s    = (sel_idx_s == PW'(NUM_PROTOCOLS - 1)) ? {PW{1'b0}} : (sel_idx_s + PW'(1));
  end

  // Arbiter FSM: lock on a non-EOP beat, release and advance RR on EOP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      grant_r  <= {PW{1'b0}};
      rr_ptr_r <= {PW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (hs_s && !lnk_tx_eop) begin
            state_r <= ST_LOCKED;
            grant_r <= win_s;
          end else if (eop_hs_s) begin
            rr_ptr_r <= next_rr_s;
          end
        end
        ST_LOCKED: begin
          if (eop_hs_s) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= next_rr_s;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ucie_multi_protocol_adapter.sv
// Scoreboard bench for ucie_multi_protocol_adapter: directed stimulus pushes
// expected flits into queues, negedge monitors pop and compare on handshakes.
module tb_ucie_multi_protocol_adapter;

  localparam int N  = 4;
  localparam int FW = 256;
  localparam int VW = 8;
  localparam int PW = 4;
  localparam int CW = 16;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    protocol_enable;
  logic            arb_mode;
  logic            lnk_rx_valid, lnk_rx_ready;
  logic [FW-1:0]   lnk_rx_data;
  logic [PW-1:0]   lnk_rx_pid;
  logic [VW-1:0]   lnk_rx_vc;
  logic [N-1:0]    proto_tx_valid, proto_tx_ready;
  logic [N*FW-1:0] proto_tx_data;
  logic [N*VW-1:0] proto_tx_vc;
  logic [N-1:0]    proto_rx_valid, proto_rx_ready, proto_rx_sop, proto_rx_eop;
  logic [N*FW-1:0] proto_rx_data;
  logic [N*VW-1:0] proto_rx_vc;
  logic            lnk_tx_valid, lnk_tx_ready, lnk_tx_sop, lnk_tx_eop;
  logic [FW-1:0]   lnk_tx_data;
  logic [VW-1:0]   lnk_tx_vc;
  logic [PW-1:0]   lnk_tx_pid;
  logic [N*CW-1:0] drop_count;
  logic [CW-1:0]   unknown_pid_count;

  ucie_multi_protocol_adapter #(
    .NUM_PROTOCOLS(N), .FLIT_W(FW), .VC_W(VW), .PID_W(PW), .FIFO_DEPTH(4), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .protocol_enable(protocol_enable), .arb_mode(arb_mode),
    .lnk_rx_valid(lnk_rx_valid), .lnk_rx_ready(lnk_rx_ready), .lnk_rx_data(lnk_rx_data),
    .lnk_rx_pid(lnk_rx_pid), .lnk_rx_vc(lnk_rx_vc),
    .proto_tx_valid(proto_tx_valid), .proto_tx_ready(proto_tx_ready),
    .proto_tx_data(proto_tx_data), .proto_tx_vc(proto_tx_vc),
    .proto_rx_valid(proto_rx_valid), .proto_rx_ready(proto_rx_ready),
    .proto_rx_data(proto_rx_data), .proto_rx_vc(proto_rx_vc),
    .proto_rx_sop(proto_rx_sop), .proto_rx_eop(proto_rx_eop),
    .lnk_tx_valid(lnk_tx_valid), .lnk_tx_ready(lnk_tx_ready), .lnk_tx_data(lnk_tx_data),
    .lnk_tx_vc(lnk_tx_vc), .lnk_tx_pid(lnk_tx_pid), .lnk_tx_sop(lnk_tx_sop),
    .lnk_tx_eop(lnk_tx_eop), .drop_count(drop_count), .unknown_pid_count(unknown_pid_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [PW-1:0] pid;
    logic [FW-1:0] data;
    logic [VW-1:0] vc;
  } dn_t;

  typedef struct packed {
    logic [PW-1:0] pid;
    logic [FW-1:0] data;
    logic [VW-1:0] vc;
    logic          sop;
    logic          eop;
  } up_t;

  dn_t dn_q[$];
  up_t up_q[$];
  up_t up_e;
  int  dn_f;
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Downstream monitor: each FIFO pop must match the oldest expected flit for that pid
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (proto_tx_valid[i] && proto_tx_ready[i]) begin
          dn_f = -1;
          for (int j = 0; j < dn_q.size(); j++)
            if (dn_f < 0 && dn_q[j].pid == PW'(i)) dn_f = j;
          if (dn_f < 0) begin
            total++;
            bad++;
            $display("FAIL dn_unexpected: pid %0d popped %0h, required no pop", i,
                     proto_tx_data[i*FW +: FW]);
          end else begin
            chk("dn_data", proto_tx_data[i*FW +: FW], dn_q[dn_f].data);
            chk("dn_vc", FW'(proto_tx_vc[i*VW +: VW]), FW'(dn_q[dn_f].vc));
            dn_q.delete(dn_f);
          end
        end
      end
    end
  end

  // Upstream monitor: each link handshake must match the next expected beat
  always @(negedge clk) begin
    if (rst_n && lnk_tx_valid && lnk_tx_ready) begin
      if (up_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL up_unexpected: pid %0d data %0h, required no beat", lnk_tx_pid, lnk_tx_data);
      end else begin
        up_e = up_q.pop_front();
        chk("up_pid", FW'(lnk_tx_pid), FW'(up_e.pid));
        chk("up_data", lnk_tx_data, up_e.data);
        chk("up_vc", FW'(lnk_tx_vc), FW'(up_e.vc));
        chk("up_sop", FW'(lnk_tx_sop), FW'(up_e.sop));
        chk("up_eop", FW'(lnk_tx_eop), FW'(up_e.eop));
        chk("up_ready", FW'(proto_rx_ready), FW'(N'(1) << up_e.pid));
      end
    end
  end

  task automatic send(input logic [PW-1:0] pid, input logic [FW-1:0] d, input logic [VW-1:0] vc,
                      input bit keep, input bit chk_imm);
    int w;
    lnk_rx_valid = 1'b1;
    lnk_rx_pid   = pid;
    lnk_rx_data  = d;
    lnk_rx_vc    = vc;
    for (w = 0; w < 20; w++) begin
      @(negedge clk);
      if (lnk_rx_ready) break;
      @(posedge clk);
      #1;
    end
    chk("rx_accept_in_budget", FW'(w < 20), FW'(1));
    if (w < 20) begin
      if (keep) dn_q.push_back('{pid, d, vc});
      if (chk_imm) chk("rx_ready_immediate", FW'(w), FW'(0));
    end
    tick();
    lnk_rx_valid = 1'b0;
  endtask

  task automatic drive_up(input int i, input bit v, input logic [FW-1:0] d, input logic [VW-1:0] vc,
                          input bit sop, input bit eop);
    proto_rx_valid[i]          = v;
    proto_rx_data[i*FW +: FW]  = d;
    proto_rx_vc[i*VW +: VW]    = vc;
    proto_rx_sop[i]            = sop;
    proto_rx_eop[i]            = eop;
  endtask

  task automatic exp_up(input int pid, input logic [FW-1:0] d, input logic [VW-1:0] vc,
                        input bit sop, input bit eop);
    up_q.push_back('{PW'(pid), d, vc, sop, eop});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    protocol_enable = 4'hF;
    arb_mode = 1'b0;
    lnk_rx_valid = 1'b0; lnk_rx_data = '0; lnk_rx_pid = '0; lnk_rx_vc = '0;
    proto_tx_ready = '0;
    proto_rx_valid = '0; proto_rx_data = '0; proto_rx_vc = '0; proto_rx_sop = '0; proto_rx_eop = '0;
    lnk_tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_proto_tx_valid", FW'(proto_tx_valid), FW'(0));
    chk("rst_lnk_tx_valid", FW'(lnk_tx_valid), FW'(0));
    chk("rst_lnk_tx_data", lnk_tx_data, FW'(0));
    chk("rst_lnk_tx_pid", FW'({lnk_tx_pid, lnk_tx_sop, lnk_tx_eop}), FW'(0));
    chk("rst_drop_count", FW'(drop_count), FW'(0));
    chk("rst_unknown", FW'(unknown_pid_count), FW'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // pid 2 flit: valid appears one cycle after the push
    lnk_rx_valid = 1'b1; lnk_rx_pid = 4'd2; lnk_rx_data = 256'hD0; lnk_rx_vc = 8'h22;
    @(negedge clk);
    chk("lat_before_push", FW'(proto_tx_valid), FW'(0));
    chk("lat_rx_ready", FW'(lnk_rx_ready), FW'(1));
    dn_q.push_back('{4'd2, 256'hD0, 8'h22});
    tick();
    lnk_rx_valid = 1'b0;
    chk("lat_after_push", FW'(proto_tx_valid), FW'(4'b0100));
    proto_tx_ready = 4'hF;
    repeat (2) tick();

    // fill protocol 1, then release it
    proto_tx_ready = 4'b1101;
    for (int k = 0; k < 4; k++) send(4'd1, FW'(32'h11 + k), 8'h31, 1'b1, 1'b1);
    lnk_rx_valid = 1'b1; lnk_rx_pid = 4'd1; lnk_rx_data = 256'h15; lnk_rx_vc = 8'h35;
    @(negedge clk);
    chk("full_rx_ready", FW'(lnk_rx_ready), FW'(0));
    tick();
    proto_tx_ready = 4'hF;
    @(negedge clk);
    chk("full_pop_rx_ready", FW'(lnk_rx_ready), FW'(0));
    tick();
    @(negedge clk);
    chk("after_pop_rx_ready", FW'(lnk_rx_ready), FW'(1));
    dn_q.push_back('{4'd1, 256'h15, 8'h35});
    tick();
    lnk_rx_valid = 1'b0;
    repeat (6) tick();

    // drops: disabled protocol 2 and out-of-range pid 7
    protocol_enable = 4'b1011;
    for (int k = 0; k < 3; k++) send(4'd2, FW'(32'h200 + k), 8'h02, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) send(4'd7, FW'(32'h700 + k), 8'h07, 1'b0, 1'b1);
    chk("drop_count", FW'(drop_count), FW'({16'd0, 16'd3, 16'd0, 16'd0}));
    chk("unknown_count", FW'(unknown_pid_count), FW'(2));
    protocol_enable = 4'hF;
    repeat (2) tick();

    // round-robin then strict priority, single-beat packets
    for (int i = 0; i < N; i++) drive_up(i, 1'b1, FW'(32'hA0 + i), VW'(8 + i), 1'b1, 1'b1);
    exp_up(0, 256'hA0, 8'd8, 1'b1, 1'b1);
    exp_up(1, 256'hA1, 8'd9, 1'b1, 1'b1);
    exp_up(2, 256'hA2, 8'd10, 1'b1, 1'b1);
    exp_up(3, 256'hA3, 8'd11, 1'b1, 1'b1);
    exp_up(0, 256'hA0, 8'd8, 1'b1, 1'b1);
    lnk_tx_ready = 1'b1;
    repeat (5) tick();
    arb_mode = 1'b1;
    for (int k = 0; k < 3; k++) exp_up(0, 256'hA0, 8'd8, 1'b1, 1'b1);
    repeat (3) tick();
    lnk_tx_ready = 1'b0;
    proto_rx_valid = '0;
    tick();

    // protocol 3 locks a 3-beat packet; mode and enable changes must wait for EOP
    arb_mode = 1'b0;
    drive_up(0, 1'b1, 256'hB0, 8'h40, 1'b1, 1'b1);
    drive_up(3, 1'b1, 256'hC0, 8'h43, 1'b1, 1'b0);
    exp_up(3, 256'hC0, 8'h43, 1'b1, 1'b0);
    exp_up(3, 256'hC1, 8'h43, 1'b0, 1'b0);
    exp_up(3, 256'hC2, 8'h43, 1'b0, 1'b1);
    exp_up(0, 256'hB0, 8'h40, 1'b1, 1'b1);
    lnk_tx_ready = 1'b1;
    tick();
    lnk_tx_ready = 1'b0;
    drive_up(3, 1'b1, 256'hC1, 8'h43, 1'b0, 1'b0);
    arb_mode = 1'b1;
    protocol_enable = 4'b0111;
    @(negedge clk);
    chk("locked_pid", FW'(lnk_tx_pid), FW'(3));
    chk("locked_valid", FW'(lnk_tx_valid), FW'(1));
    chk("locked_ready_low", FW'(proto_rx_ready), FW'(0));
    tick();
    lnk_tx_ready = 1'b1;
    tick();
    lnk_tx_ready = 1'b0;
    drive_up(3, 1'b1, 256'hC2, 8'h43, 1'b0, 1'b1);
    tick();
    lnk_tx_ready = 1'b1;
    tick();
    lnk_tx_ready = 1'b0;
    drive_up(3, 1'b0, 256'h0, 8'h0, 1'b0, 1'b0);
    protocol_enable = 4'hF;
    tick();
    lnk_tx_ready = 1'b1;
    tick();
    lnk_tx_ready = 1'b0;
    drive_up(0, 1'b0, 256'h0, 8'h0, 1'b0, 1'b0);
    arb_mode = 1'b0;
    tick();

    // reset in the middle of a locked packet with protocol 0 FIFO partly full
    proto_tx_ready = 4'b1110;
    send(4'd0, 256'hE1, 8'h51, 1'b1, 1'b1);
    send(4'd0, 256'hE2, 8'h51, 1'b1, 1'b1);
    drive_up(2, 1'b1, 256'hF0, 8'h52, 1'b1, 1'b0);
    exp_up(2, 256'hF0, 8'h52, 1'b1, 1'b0);
    lnk_tx_ready = 1'b1;
    tick();
    lnk_tx_ready = 1'b0;
    drive_up(2, 1'b1, 256'hF1, 8'h52, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    proto_rx_valid = '0;
    dn_q.delete();
    @(negedge clk);
    chk("mid_rst_proto_tx_valid", FW'(proto_tx_valid), FW'(0));
    chk("mid_rst_lnk_tx_valid", FW'(lnk_tx_valid), FW'(0));
    chk("mid_rst_drop_count", FW'(drop_count), FW'(0));
    chk("mid_rst_unknown", FW'(unknown_pid_count), FW'(0));
    tick();
    rst_n = 1'b1;
    proto_tx_ready = 4'hF;
    for (int i = 0; i < N; i++) drive_up(i, 1'b1, FW'(32'h90 + i), VW'(i), 1'b1, 1'b1);
    exp_up(0, 256'h90, 8'd0, 1'b1, 1'b1);
    exp_up(1, 256'h91, 8'd1, 1'b1, 1'b1);
    lnk_tx_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_proto_tx_valid", FW'(proto_tx_valid), FW'(0));
    tick();
    tick();
    lnk_tx_ready = 1'b0;
    proto_rx_valid = '0;
    repeat (3) tick();

    chk("dn_queue_drained", FW'(dn_q.size()), FW'(0));
    chk("up_queue_drained", FW'(up_q.size()), FW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
